// File: rtl/updown_counter4_pkg.sv
// -----------------------------------------------------------------------------
// updown_counter4_pkg
//
// Shared constants for the LED up/down counter demo:
//   CLK_HZ            nominal board clock frequency (Hz)
//   DEFAULT_DIV_COUNT clk cycles per count step (one step per second)
//   DIR_UP / DIR_DOWN encodings of the up_down input
//   pre_width()       prescaler register width for a given divide ratio
// -----------------------------------------------------------------------------
package updown_counter4_pkg;

    localparam int CLK_HZ            = 50000000;
    localparam int DEFAULT_DIV_COUNT = CLK_HZ;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width needed to hold 0..div-1. A divide ratio of 1 or 2 still gets a
    // one-bit register so the prescaler never collapses to a zero-width vector.
    function automatic int pre_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage : updown_counter4_pkg

// File: rtl/updown_counter4_tick_gen.sv
// -----------------------------------------------------------------------------
// updown_counter4_tick_gen
//
// Prescaler producing a one-cycle tick every DIV_COUNT clk cycles.
//
// Ports:
//   clk     in   system clock, rising edge
//   nreset  in   synchronous reset, active high (1 = in reset)
//   tick    out  high for one cycle while the prescaler sits at DIV_COUNT-1
//
// Parameters:
//   DIV_COUNT  clk cycles per tick, must be >= 1. With DIV_COUNT = 1 the
//              prescaler stays at 0 and tick is high every cycle.
// -----------------------------------------------------------------------------
module updown_counter4_tick_gen
    import updown_counter4_pkg::*;
#(
    parameter int DIV_COUNT = DEFAULT_DIV_COUNT
) (
    input  logic clk,
    input  logic nreset,
    output logic tick
);

    localparam int PRE_W = pre_width(DIV_COUNT);

    // Terminal value of the prescaler, sized to the register.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_COUNT - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             at_last;

    // The tick is decoded from the register, so it is glitch-free relative to
    // clk and the first tick after reset lands on the DIV_COUNT-th edge.
    assign at_last = (pre_q == PRE_LAST);
    assign tick    = at_last;

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (at_last) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : updown_counter4_tick_gen

// File: rtl/updown_counter4.sv
// -----------------------------------------------------------------------------
// updown_counter4
//
// Free-running up/down counter for a board demo. The count advances once per
// prescaler tick so it is slow enough to watch on LEDs.
//
// Ports:
//   clk      in   system clock (50 MHz nominal), rising edge
//   nreset   in   synchronous reset, active high (1 = in reset)
//   up_down  in   direction, DIR_UP = count up, DIR_DOWN = count down;
//                 only looked at on tick edges
//   cnter    out  registered count value, WIDTH bits, wraps both ways
//   out_oe   out  output enables for the cnter pins, always all ones
//   osc_en   out  on-chip oscillator enable, always 1
//
// Parameters:
//   WIDTH      counter width (and out_oe width)
//   DIV_COUNT  clk cycles per count step, >= 1
// -----------------------------------------------------------------------------
module updown_counter4
    import updown_counter4_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV_COUNT = DEFAULT_DIV_COUNT
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             up_down,
    output logic [WIDTH-1:0] cnter,
    output logic [WIDTH-1:0] out_oe,
    output logic             osc_en
);

    logic             tick;
    logic [WIDTH-1:0] cnter_q;
    logic [WIDTH-1:0] cnter_d;

    updown_counter4_tick_gen #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick_gen (
        .clk    (clk),
        .nreset (nreset),
        .tick   (tick)
    );

    // Natural modular arithmetic of a WIDTH-bit vector gives the 15->0 and
    // 0->15 wraps for free.
    always_comb begin
        cnter_d = cnter_q;
        if (tick) begin
            if (up_down == DIR_UP) begin
                cnter_d = cnter_q + WIDTH'(1);
            end else begin
                cnter_d = cnter_q - WIDTH'(1);
            end
        end
    end

    // Reset wins over tick and direction.
    always_ff @(posedge clk) begin
        if (nreset) begin
            cnter_q <= '0;
        end else begin
            cnter_q <= cnter_d;
        end
    end

    assign cnter = cnter_q;

    // Pins are driven at all times, reset included, so the enables are tied
    // high bit by bit rather than derived from any state.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_out_oe
            assign out_oe[gi] = 1'b1;
        end
    endgenerate

    assign osc_en = 1'b1;

endmodule : updown_counter4

// File: tb/tb_updown_counter4.sv
// -----------------------------------------------------------------------------
// tb_updown_counter4
//
// Two instances share clk, nreset and up_down: one with DIV_COUNT = 4 and one
// with DIV_COUNT = 1. A reference model tracks cycles since the last reset
// edge and steps the count whenever that number is a multiple of the divide
// ratio. Directed phases walk the test plan, then a random phase follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updown_counter4;

    localparam int WIDTH = 4;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic             clk;
    logic             nreset;
    logic             up_down;
    logic [WIDTH-1:0] cnter_a;
    logic [WIDTH-1:0] out_oe_a;
    logic             osc_en_a;
    logic [WIDTH-1:0] cnter_b;
    logic [WIDTH-1:0] out_oe_b;
    logic             osc_en_b;

    int n_compared;
    int n_mismatched;

    // reference model state
    int model_a;
    int model_b;
    int since_rst;

    updown_counter4 #(
        .WIDTH     (WIDTH),
        .DIV_COUNT (DIV_A)
    ) dut_a (
        .clk     (clk),
        .nreset  (nreset),
        .up_down (up_down),
        .cnter   (cnter_a),
        .out_oe  (out_oe_a),
        .osc_en  (osc_en_a)
    );

    updown_counter4 #(
        .WIDTH     (WIDTH),
        .DIV_COUNT (DIV_B)
    ) dut_b (
        .clk     (clk),
        .nreset  (nreset),
        .up_down (up_down),
        .cnter   (cnter_b),
        .out_oe  (out_oe_b),
        .osc_en  (osc_en_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare all outputs 1 ns later.
    task automatic cycle(input string phase);
        int step;
        @(posedge clk);
        step = up_down ? 1 : -1;
        if (nreset) begin
            model_a   = 0;
            model_b   = 0;
            since_rst = 0;
        end else begin
            since_rst++;
            if (since_rst % DIV_A == 0) model_a = (model_a + step + 16) % 16;
            if (since_rst % DIV_B == 0) model_b = (model_b + step + 16) % 16;
        end
        #1;
        chk("cnter_div4", int'(cnter_a), model_a);
        chk("cnter_div1", int'(cnter_b), model_b);
        chk("out_oe_div4", int'(out_oe_a), 15);
        chk("out_oe_div1", int'(out_oe_b), 15);
        chk("osc_en_div4", int'(osc_en_a), 1);
        chk("osc_en_div1", int'(osc_en_b), 1);
        $display("%s rst=%0b ud=%0b k=%0d cnt4=%0d cnt1=%0d", phase, nreset,
                 up_down, since_rst, cnter_a, cnter_b);
    endtask

    initial begin
        int found;
        n_compared   = 0;
        n_mismatched = 0;
        model_a      = 0;
        model_b      = 0;
        since_rst    = 0;
        nreset       = 1'b1;
        up_down      = 1'b1;

        // reset held for five cycles
        for (int i = 0; i < 5; i++) cycle("reset");
        chk("reset_cnt4", int'(cnter_a), 0);

        // count up: 1 at cycle 4, 12 at cycle 48, then past the up wrap
        nreset = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            cycle("up");
            if (i == 3)  chk("up_c3", int'(cnter_a), 0);
            if (i == 4)  chk("up_c4", int'(cnter_a), 1);
            if (i == 48) chk("up_c48", int'(cnter_a), 12);
            if (i == 60) chk("up_c60", int'(cnter_a), 15);
            if (i == 63) chk("up_c63", int'(cnter_a), 15);
            if (i == 64) chk("up_wrap", int'(cnter_a), 0);
        end

        // switch to down once the count reaches 5
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cycle("seek5");
            if (model_a == 5) found = 1;
        end
        chk("seek5_found", found, 1);
        up_down = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            cycle("down");
            if (i == 20) chk("down_c20", int'(cnter_a), 0);
            if (i == 24) chk("down_wrap", int'(cnter_a), 15);
        end

        // mid-operation reset at count 9
        up_down = 1'b1;
        found   = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            cycle("seek9");
            if (model_a == 9) found = 1;
        end
        chk("seek9_found", found, 1);
        nreset = 1'b1;
        cycle("midrst");
        chk("midrst_cnt4", int'(cnter_a), 0);
        nreset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cycle("afterrst");
            if (i == 3) chk("afterrst_c3", int'(cnter_a), 0);
            if (i == 4) chk("afterrst_c4", int'(cnter_a), 1);
        end

        // random direction changes and occasional resets
        for (int i = 0; i < 400; i++) begin
            up_down = 1'($urandom_range(0, 1));
            nreset  = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_updown_counter4

// File: doc/updown_counter4.md
Name: updown_counter4

Overview:
- Free-running 4-bit up/down counter for a board-level FPGA demo. It is advanced by an internal prescaler tick, so the count is visible on LEDs or pins.
- Sits at top level: drives 4 output pins directly, plus pin output-enables and the on-chip oscillator enable.
- Direction is selected by a static input.

Parameters:
- WIDTH, 4, counter width in bits; port widths of cnter and out_oe follow it.
- DIV_COUNT, 50000000, clk cycles per count step (1 Hz at 50 MHz); must be >= 1. Simulation overrides it to a small value, e.g. 4.

Ports:
- clk  in  1  system clock, 50 MHz nominal; all logic on rising edge.
- nreset  in  1  reset, synchronous, active-high. 1 = reset asserted (port name kept as used in the codebase).
- up_down  in  1  direction: 1 = count up, 0 = count down.
- cnter  out  WIDTH  current count value, registered.
- out_oe  out  WIDTH  output-enable for the cnter pins.
- osc_en  out  1  enable for the on-chip oscillator feeding clk.

Behaviour:
- Reset (nreset=1 sampled at a clk rising edge):
  - cnter <= 0 and prescaler count <= 0 on that edge.
  - Reset has priority over tick and direction.
  - Reset mid-count returns cnter to 0 at the next edge; the prescaler phase restarts from 0.
- Prescaler:
  - Counter pre counts 0..DIV_COUNT-1, increments every clk, wraps to 0.
  - tick = 1 for exactly one cycle when pre == DIV_COUNT-1.
  - DIV_COUNT=1: tick is high every cycle.
  - Width of pre = clog2(DIV_COUNT), minimum 1 bit.
- Count update (on a clk edge with tick=1 and not in reset):
  - up_down=1: cnter <= cnter+1 mod 2^WIDTH (15 -> 0 wrap).
  - up_down=0: cnter <= cnter-1 mod 2^WIDTH (0 -> 15 wrap).
- Without tick, cnter holds.
- up_down is sampled only on tick edges. Changes between ticks have no effect until the next tick. No synchronizer is needed in sim; in hardware up_down is quasi-static.
- First count step after reset release:
  - The first tick occurs DIV_COUNT cycles after the last reset edge.
  - cnter changes on that edge, i.e. the first step happens on the DIV_COUNT-th clk edge after nreset falls.
- out_oe: constant all-ones (pins always driven), including during reset.
- osc_en: constant 1, including during reset.
- No X on any output after the first clk edge with reset asserted.

Decomposition:
- Shared package holds:
  - the default DIV_COUNT constant (CLK_HZ=50000000);
  - the DIR_UP=1 and DIR_DOWN=0 encodings.
- One natural sub-module, tick_gen, holds the parameterised prescaler. Its interface is clk and nreset in, tick out, with parameter DIV_COUNT.
- The top holds the count register and the constant outputs.

Test Plan (DIV_COUNT=4, clk period 20 ns):
- Reset: nreset=1 for 5 cycles -> cnter=0, out_oe=4'hF, osc_en=1 throughout.
- Count up: release reset, up_down=1, run 50 cycles -> cnter steps every 4 cycles: 1,2,3,... ; 1 at cycle 4, 12 at cycle 48.
- Up wrap: keep counting up past 15 -> 15 is followed by 0 after 4 more cycles.
- Count down: switch up_down=0 at cnter=5 -> next ticks give 4,3,2,1,0, then 15 (down wrap).
- Mid-operation reset: assert nreset=1 for 1 cycle at cnter=9 -> cnter=0 on that edge. After release, the next step (to 1 if up_down=1) comes exactly 4 cycles later.
- DIV_COUNT=1 build: up_down=1 -> cnter increments every clk. Toggling up_down reverses direction on the very next edge.
